// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-driven X/Z muxes, 48-bit add/sub with carry-in, P feedback.
// Optional signed-overflow flag enabled by defining POSTADD_OVF_EN.
module dsp_post_adder_acc #(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG   = 1,
    parameter int CARRYINREG  = 1,
    parameter int CARRYINSEL  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEP,
    input  logic        CEOPMODE,
    input  logic        CECARRYIN,
    input  logic [7:0]  OPMODE,
    input  logic [35:0] M,
    input  logic [47:0] DAB,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF,
    output logic        OVERFLOW
);

    logic [7:0]  opm;
    logic        cin_raw;
    logic        cin;
    logic [47:0] p_fb;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] r;
    logic [47:0] p_d;
    logic        co_d;

    generate
        if (OPMODEREG != 0) begin : g_opm_reg
            logic [7:0] opm_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    opm_q <= '0;
                else if (CEOPMODE)
                    opm_q <= OPMODE;
            end
            assign opm = opm_q;
        end else begin : g_opm_wire
            assign opm = OPMODE;
        end

        if (CARRYINSEL != 0) begin : g_cin_opm
            assign cin_raw = opm[5];
        end else begin : g_cin_port
            assign cin_raw = CARRYIN;
        end

        if (CARRYINREG != 0) begin : g_cin_reg
            logic cin_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    cin_q <= 1'b0;
                else if (CECARRYIN)
                    cin_q <= cin_raw;
            end
            assign cin = cin_q;
        end else begin : g_cin_wire
            assign cin = cin_raw;
        end
    endgenerate

    always_comb begin
        x_mux = '0;
        case (opm[1:0])
            2'd0:    x_mux = '0;
            2'd1:    x_mux = {{12{M[35]}}, M};
            2'd2:    x_mux = p_fb;
            default: x_mux = DAB;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (opm[3:2])
            2'd0:    z_mux = '0;
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = p_fb;
            default: z_mux = C;
        endcase
    end

    // Bit 48 of the subtract result is the borrow out.
    always_comb begin
        r = '0;
        if (opm[7])
            r = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin});
        else
            r = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};
    end

    assign p_d  = r[47:0];
    assign co_d = r[48];

    generate
        if (PREG != 0) begin : g_p_reg
            logic [47:0] p_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    p_q <= '0;
                else if (CEP)
                    p_q <= p_d;
            end
            assign P    = p_q;
            assign p_fb = p_q;
        end else begin : g_p_wire
            // Without a P register, feedback reads as zero to avoid a combinational loop.
            assign P    = p_d;
            assign p_fb = '0;
        end

        if (CARRYOUTREG != 0) begin : g_co_reg
            logic co_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    co_q <= 1'b0;
                else if (CEP)
                    co_q <= co_d;
            end
            assign CARRYOUT = co_q;
        end else begin : g_co_wire
            assign CARRYOUT = co_d;
        end
    endgenerate

`ifdef POSTADD_OVF_EN
    logic ovf_d;
    always_comb begin
        ovf_d = 1'b0;
        if (opm[7])
            ovf_d = (x_mux[47] != z_mux[47]) && (r[47] != z_mux[47]);
        else
            ovf_d = (x_mux[47] == z_mux[47]) && (r[47] != z_mux[47]);
    end

    generate
        if (CARRYOUTREG != 0) begin : g_ovf_reg
            logic ovf_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    ovf_q <= 1'b0;
                else if (CEP)
                    ovf_q <= ovf_d;
            end
            assign OVERFLOW = ovf_q;
        end else begin : g_ovf_wire
            assign OVERFLOW = ovf_d;
        end
    endgenerate
`else
    assign OVERFLOW = 1'b0;
`endif

    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;

    // Ignored OPMODE bits and inputs that some parameter sets leave unconnected.
    logic unused_ok;
    assign unused_ok = ^{opm[6], opm[4], CARRYIN, CEP, CEOPMODE, CECARRYIN};

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice. It sits directly downstream of the M-path pipeline-select mux and consumes the selected 36-bit multiplier product.
- X/Z operand muxes are controlled by OPMODE. Contains a 48-bit adder/subtractor with carry-in, P and CARRYOUT registers, and P feedback for multiply-accumulate.
- Drives P, PCOUT (cascade to the next slice) and CARRYOUT/CARRYOUTF.

Parameters:
- PREG, 1: 1 = P register present; 0 = P is combinational.
- CARRYOUTREG, 1: 1 = CARRYOUT register present; 0 = combinational.
- OPMODEREG, 1: 1 = OPMODE register present; 0 = OPMODE used directly.
- CARRYINREG, 1: 1 = carry-in register present; 0 = combinational.
- CARRYINSEL, 1: 1 = carry-in taken from OPMODE[5]; 0 = taken from CARRYIN port.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset of all internal registers.
- CEP  input  1  clock enable for P register and CARRYOUT register.
- CEOPMODE  input  1  clock enable for OPMODE register.
- CECARRYIN  input  1  clock enable for carry-in register.
- OPMODE  input  8  [1:0] X select, [3:2] Z select, [5] carry-in bit, [7] subtract; other bits ignored.
- M  input  36  signed multiplier product from the upstream mux.
- DAB  input  48  concatenation {D[11:0],A[17:0],B[17:0]}.
- C  input  48  C operand.
- PCIN  input  48  cascade input from the previous slice.
- CARRYIN  input  1  external carry-in.
- P  output  48  post-adder result.
- PCOUT  output  48  always equal to P.
- CARRYOUT  output  1  carry/borrow out of bit 47.
- CARRYOUTF  output  1  always equal to CARRYOUT.
- OVERFLOW  output  1  signed-overflow flag (optional feature).

Behaviour:
- Reset:
  - RST is asynchronous and active-high. It clears the OPMODE register, carry-in register, P, CARRYOUT and OVERFLOW to 0 immediately, without waiting for CLK.
  - RST has priority over every CE.
  - Reset asserted mid-accumulation discards the accumulated value. The first edge after release with CEP=1 starts from P=0.
- Registers:
  - Each register loads on the rising CLK edge only when its CE=1; otherwise it holds its value.
  - A register whose parameter is 0 is replaced by a wire, and its CE is ignored.
- Effective OPMODE (opm): the OPMODE register output when OPMODEREG=1, else the OPMODE port directly.
- X mux, selected by opm[1:0]:
  - 0: 0.
  - 1: M sign-extended to 48 bits.
  - 2: P feedback.
  - 3: DAB.
- Z mux, selected by opm[3:2]:
  - 0: 0.
  - 1: PCIN.
  - 2: P feedback.
  - 3: C.
- Carry-in source:
  - cin_raw = opm[5] when CARRYINSEL=1, else the CARRYIN port.
  - cin = cin_raw registered under CECARRYIN when CARRYINREG=1, else cin_raw directly.
- P feedback when PREG=0: selecting P in X or Z yields 0. This prevents a combinational loop.
- Arithmetic: all operands are zero-extended to 49 bits.
  - opm[7]=0: r = Z + X + cin.
  - opm[7]=1: r = Z − (X + cin).
  - Next P = r[47:0]. Next CARRYOUT = r[48]; for subtract this is the borrow.
  - Wrap-around is modulo 2^48 with no saturation.
- Latency, measured from a stable M/DAB/C/PCIN input to P:
  - PREG=1: 1 clock.
  - PREG=0: combinational.
  - OPMODEREG=1 and CARRYINREG=1 each add one cycle for their own control path only. Data is not delayed by them.
- Accumulate: with opm X=M and Z=P, each CEP=1 edge adds M to P.
  - CEP=0 freezes P and CARRYOUT, even while M changes.
  - If CEOPMODE changes opm in the same edge, the new mode takes effect from the next edge.

Optional Feature:
- Macro: POSTADD_OVF_EN.
- When defined, OVERFLOW reports signed overflow of the 48-bit result:
  - Add: X[47] == (Z[47] XOR 0) and r[47] != Z[47].
  - Subtract: X[47] != Z[47] and r[47] != Z[47].
  - Timing follows CARRYOUT: registered under CEP when CARRYOUTREG=1, combinational otherwise.
  - Reset value is 0.
- When undefined, OVERFLOW is tied to 0 and no extra logic is generated.

Test Plan:
- Reset:
  - Stimulus: all registers loaded nonzero, then RST asserted between clock edges.
  - Required: P=0, CARRYOUT=0 and PCOUT=0 before the next edge.
  - Stimulus: RST held 1 with CEP=1 and live inputs.
  - Required: outputs stay 0.
- Multiply-accumulate:
  - Stimulus: OPMODE=8'h09 (X=M, Z=P), M=36'd5, CEP=1 for 4 edges from reset.
  - Required: P=5, 10, 15, 20. Then with CEP=0, P holds 20.
- Subtract with borrow:
  - Stimulus: OPMODE=8'h8D (Z=C, X=M, subtract), C=48'd3, M=36'd5, cin=0.
  - Required: P=48'hFFFF_FFFF_FFFE, CARRYOUT=1.
- Carry-in and wrap:
  - Stimulus: CARRYINSEL=1, OPMODE=8'h2F (X=DAB, Z=C, opm[5]=1), DAB=48'hFFFF_FFFF_FFFF, C=0.
  - Required: P=0, CARRYOUT=1, with the carry-in register delay honoured.
- Sign extension and cascade:
  - Stimulus: M=36'h8_0000_0000, PCIN=48'd1, OPMODE=8'h05.
  - Required: P=PCOUT=48'hFFF8_0000_0001.
- PREG=0 instance:
  - Stimulus: OPMODE=8'h0A (X=P, Z=P).
  - Required: P=0 combinationally, with no oscillation.
  - Stimulus (POSTADD_OVF_EN defined): add 48'h7FFF_FFFF_FFFF + 1.
  - Required: OVERFLOW=1.
